// File: rtl/reg_file_wb.sv
// RV32I integer register file: 32 x XLEN, x0 hardwired to zero, one write port shared by ALU and load
// writebacks through a one-entry pending buffer, registered reads with write bypass. Optional REGFILE_DEBUG_PORT_EN.
module reg_file_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            read_en,
  input  logic [4:0]      src1_addr,
  input  logic [4:0]      src2_addr,
  output logic [XLEN-1:0] src1_value,
  output logic [XLEN-1:0] src2_value,
  output logic            read_valid,
  input  logic            alu_done,
  input  logic [4:0]      write_addr,
  input  logic [XLEN-1:0] result,
  input  logic            load_done,
  input  logic [4:0]      load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            dbg_pending
`endif
);

  logic [XLEN-1:0] regs_q [NREG];

  logic            pend_valid_q, pend_valid_d;
  logic [4:0]      pend_addr_q, pend_addr_d;
  logic [XLEN-1:0] pend_data_q, pend_data_d;

  logic            wr_en_d;
  logic [4:0]      wr_addr_d;
  logic [XLEN-1:0] wr_data_d;

  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic            read_valid_q;

  logic alu_wr;
  logic load_acc;

  assign load_ready = !pend_valid_q;
  assign alu_wr     = alu_done && (write_addr != 5'd0);
  assign load_acc   = load_done && load_ready && (load_addr != 5'd0);

  // Write-port arbitration: ALU first, then pending drain, then a direct load.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = 5'd0;
    wr_data_d    = '0;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (alu_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = write_addr;
      wr_data_d = result;
      // A younger ALU write to the same register makes the pending load stale.
      if (pend_valid_q && (pend_addr_q == write_addr)) begin
        pend_valid_d = 1'b0;
      end
      if (load_acc) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = load_addr;
        pend_data_d  = load_data;
      end
    end else if (pend_valid_q) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = pend_addr_q;
      wr_data_d    = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (load_acc) begin
      wr_en_d   = 1'b1;
      wr_addr_d = load_addr;
      wr_data_d = load_data;
    end
  end

  function automatic logic [XLEN-1:0] read_bypass(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] arr_val
  );
    logic [XLEN-1:0] val;
    if (addr == 5'd0) begin
      val = '0;
    end else if (alu_wr && (write_addr == addr)) begin
      val = result;
    end else if (wr_en_d && (wr_addr_d == addr)) begin
      val = wr_data_d;
    end else if (pend_valid_q && (pend_addr_q == addr)) begin
      val = pend_data_q;
    end else begin
      val = arr_val;
    end
    return val;
  endfunction

  always_comb begin
    src1_d = src1_q;
    src2_d = src2_q;
    if (read_en) begin
      src1_d = read_bypass(src1_addr, regs_q[src1_addr]);
      src2_d = read_bypass(src2_addr, regs_q[src2_addr]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      pend_data_q  <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      read_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      read_valid_q <= read_en;
    end
  end

  assign src1_value = src1_q;
  assign src2_value = src2_q;
  assign read_valid = read_valid_q;

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
  assign dbg_pending = pend_valid_q;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: reads, ALU/load arbitration, pending buffer, bypass, x0, reset.
module tb_reg_file_wb;

  logic        clk;
  logic        reset_n;
  logic        read_en;
  logic [4:0]  src1_addr, src2_addr;
  logic [31:0] src1_value, src2_value;
  logic        read_valid;
  logic        alu_done;
  logic [4:0]  write_addr;
  logic [31:0] result;
  logic        load_done;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_wb #(.XLEN(32), .NREG(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_en    (read_en),
    .src1_addr  (src1_addr),
    .src2_addr  (src2_addr),
    .src1_value (src1_value),
    .src2_value (src2_value),
    .read_valid (read_valid),
    .alu_done   (alu_done),
    .write_addr (write_addr),
    .result     (result),
    .load_done  (load_done),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en = 0; alu_done = 0; load_done = 0;
    src1_addr = 0; src2_addr = 0; write_addr = 0; result = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_done = 1; write_addr = a; result = d;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    load_done = 1; load_addr = a; load_data = d;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    read_en = 1; src1_addr = a1; src2_addr = a2;
  endtask

  initial begin
    idle();
    reset_n = 0;
    #2;
    check_eq("rst_read_valid", {31'd0, read_valid}, 32'd0);
    check_eq("rst_src1", src1_value, 32'd0);
    check_eq("rst_load_ready", {31'd0, load_ready}, 32'd1);
    step(); step();
    reset_n = 1;
    step();

    // Basic read after reset
    rd(5'd1, 5'd0);
    step();
    idle();
    check_eq("rd1_valid", {31'd0, read_valid}, 32'd1);
    check_eq("rd1_src1", src1_value, 32'd0);
    check_eq("rd1_src2", src2_value, 32'd0);
    check_eq("rd1_load_ready", {31'd0, load_ready}, 32'd1);
    step();
    check_eq("rd1_valid_pulse", {31'd0, read_valid}, 32'd0);

    // ALU write then read
    alu(5'd5, 32'h12345678);
    step(); idle(); step();
    rd(5'd5, 5'd5);
    step(); idle();
    check_eq("alu_x5_src1", src1_value, 32'h12345678);
    check_eq("alu_x5_src2", src2_value, 32'h12345678);
    step();
    check_eq("hold_src1", src1_value, 32'h12345678);

    // ALU and load collide: load parked, drains next cycle
    alu(5'd3, 32'hAAAA0000);
    ld(5'd4, 32'h0000BBBB);
    step(); idle();
    check_eq("conf_load_ready_low", {31'd0, load_ready}, 32'd0);
    rd(5'd3, 5'd4);
    step(); idle();
    check_eq("conf_load_ready_back", {31'd0, load_ready}, 32'd1);
    check_eq("conf_x3", src1_value, 32'hAAAA0000);
    check_eq("conf_x4_commit_byp", src2_value, 32'h0000BBBB);
    rd(5'd4, 5'd3);
    step(); idle();
    check_eq("conf_x4_array", src1_value, 32'h0000BBBB);

    // WAW: ALU overwrites the register a pending load targets
    alu(5'd8, 32'h00000001);
    ld(5'd7, 32'h00000011);
    step(); idle();
    check_eq("waw_pending", {31'd0, load_ready}, 32'd0);
    alu(5'd7, 32'h00000022);
    step(); idle();
    check_eq("waw_dropped_ready", {31'd0, load_ready}, 32'd1);
    step();
    rd(5'd7, 5'd8);
    step(); idle();
    check_eq("waw_x7", src1_value, 32'h00000022);
    check_eq("waw_x8", src2_value, 32'h00000001);

    // Bypass of a pending entry still blocked by ALU traffic
    alu(5'd10, 32'h0000A0A0);
    ld(5'd11, 32'h00000077);
    step(); idle();
    alu(5'd12, 32'h0000C0C0);
    rd(5'd11, 5'd12);
    step(); idle();
    check_eq("byp_pending_x11", src1_value, 32'h00000077);
    check_eq("byp_alu_x12", src2_value, 32'h0000C0C0);
    step();
    rd(5'd11, 5'd10);
    step(); idle();
    check_eq("drain_x11", src1_value, 32'h00000077);
    check_eq("drain_x10", src2_value, 32'h0000A0A0);

    // Same-cycle ALU bypass, x0 writes dropped
    alu(5'd9, 32'hDEADBEEF);
    rd(5'd9, 5'd0);
    step(); idle();
    check_eq("byp_alu_x9", src1_value, 32'hDEADBEEF);
    alu(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd9);
    step(); idle();
    check_eq("x0_byp", src1_value, 32'd0);
    check_eq("x9_keep", src2_value, 32'hDEADBEEF);
    rd(5'd0, 5'd0);
    step(); idle();
    check_eq("x0_array", src1_value, 32'd0);
    alu(5'd13, 32'h13131313);
    ld(5'd0, 32'hFFFFFFFF);
    step(); idle();
    check_eq("x0_load_not_pending", {31'd0, load_ready}, 32'd1);

    // Reset drops a pending load and an in-flight read
    alu(5'd2, 32'h00000002);
    ld(5'd6, 32'h0000005A);
    rd(5'd1, 5'd1);
    step(); idle();
    check_eq("prerst_load_ready", {31'd0, load_ready}, 32'd0);
    check_eq("prerst_read_valid", {31'd0, read_valid}, 32'd1);
    reset_n = 0;
    #2;
    check_eq("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    check_eq("midrst_read_valid", {31'd0, read_valid}, 32'd0);
    step();
    reset_n = 1;
    step();
    rd(5'd6, 5'd2);
    step(); idle();
    check_eq("postrst_x6", src1_value, 32'd0);
    check_eq("postrst_x2", src2_value, 32'd0);
    check_eq("postrst_load_ready", {31'd0, load_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
